pipe_stage_skid: RTL and testbench

//  Parametrised pipeline stage register for the PipeLineProcessor (EX/MEM, MEM/WB, ...).

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_entry_reg.sv | 25 ++
 rtl/pipe_stage_skid.sv | 123 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding, default bubble control and payload sizing for the pipeline stage
package pipe_pkg;

    // Occupancy of the stage: no entry, main register only, main plus skid register.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

    // Control vector driven while no valid entry is presented ({RegWrite,MemToReg,MemRead,MemWrite} all off).
    localparam logic [3:0] DEFAULT_NOP_CTRL = 4'b0000;

    // Width of a packed {ctrl, data_a, data_b, dst} payload.
    function automatic int payload_w(input int ctrl_w, input int data_w, input int dst_w);
        return ctrl_w + 2 * data_w + dst_w;
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - enable-loaded payload register with asynchronous clear
module pipe_entry_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] payload_q;

    // Capture the payload only when the stage decides this slot takes a new entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            payload_q <= '0;
        end else if (en_i) begin
            payload_q <= d_i;
        end
    end

    assign q_o = payload_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - pipeline stage register with valid/ready handshake, skid buffer and flush
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                CTRL_W   = 4,
    parameter int                DST_W    = 5,
    parameter int                SKID     = 1,
    parameter logic [CTRL_W-1:0] NOP_CTRL = CTRL_W'(DEFAULT_NOP_CTRL)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data_a,
    input  logic [DATA_W-1:0] in_data_b,
    input  logic [DST_W-1:0]  in_dst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data_a,
    output logic [DATA_W-1:0] out_data_b,
    output logic [DST_W-1:0]  out_dst
);

    localparam int PW = payload_w(CTRL_W, DATA_W, DST_W);

    pipe_state_e       state_q;
    logic [PW-1:0]     in_payload;
    logic [PW-1:0]     m_d;
    logic [PW-1:0]     m_q;
    logic [PW-1:0]     s_q;
    logic              m_en;
    logic              s_en;
    logic              in_fire;
    logic              out_fire;
    logic [CTRL_W-1:0] m_ctrl;

    assign in_payload = {in_ctrl, in_data_a, in_data_b, in_dst};

    // The head entry always lives in M, so validity is simply "stage not empty".
    assign out_valid = (state_q != ST_EMPTY);

    // With the skid slot, ready depends only on registered occupancy, breaking the
    // out_ready->in_ready timing path; without it, ready passes back combinationally.
    assign in_ready = (SKID != 0) ? (state_q != ST_TWO) : (!out_valid || out_ready);

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Decide which payload slot loads this cycle; flush suppresses every load.
    always_comb begin
        m_en = 1'b0;
        s_en = 1'b0;
        m_d  = in_payload;
        if (!flush) begin
            case (state_q)
                ST_EMPTY: m_en = in_fire;
                ST_ONE: begin
                    m_en = in_fire && out_fire;
                    s_en = in_fire && !out_fire;
                end
                ST_TWO: begin
                    m_en = out_fire;
                    m_d  = s_q;
                end
                default: ;
            endcase
        end
    end

    // Occupancy FSM; flush outranks any handshake in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else if (flush) begin
            state_q <= ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (in_fire) state_q <= ST_ONE;
                ST_ONE: begin
                    if (in_fire && !out_fire) begin
                        state_q <= ST_TWO;
                    end else if (!in_fire && out_fire) begin
                        state_q <= ST_EMPTY;
                    end
                end
                ST_TWO:   if (out_fire) state_q <= ST_ONE;
                default:  state_q <= ST_EMPTY;
            endcase
        end
    end

    pipe_entry_reg #(.W(PW)) u_main (
        .clk  (clk),
        .rst  (rst),
        .en_i (m_en),
        .d_i  (m_d),
        .q_o  (m_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_entry_reg #(.W(PW)) u_skid (
                .clk  (clk),
                .rst  (rst),
                .en_i (s_en),
                .d_i  (in_payload),
                .q_o  (s_q)
            );
        end else begin : g_no_skid
            assign s_q = '0;
        end
    endgenerate

    assign {m_ctrl, out_data_a, out_data_b, out_dst} = m_q;

    // Bubbles must never carry write enables downstream.
    assign out_ctrl = out_valid ? m_ctrl : NOP_CTRL;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - randomized scoreboard bench for pipe_stage_skid
module tb_pipe_stage_skid;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_ctrl = '0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [4:0]  in_dst = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_ctrl;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [4:0]  out_dst;

    logic        z_flush = 1'b0;
    logic        z_in_valid = 1'b0;
    logic        z_in_ready;
    logic [3:0]  z_in_ctrl = '0;
    logic [31:0] z_in_a = '0;
    logic [31:0] z_in_b = '0;
    logic [4:0]  z_in_dst = '0;
    logic        z_out_valid;
    logic        z_out_ready = 1'b0;
    logic [3:0]  z_out_ctrl;
    logic [31:0] z_out_a;
    logic [31:0] z_out_b;
    logic [4:0]  z_out_dst;

    int checks = 0;
    int passes = 0;
    ent_t exp_q[$];

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(4), .DST_W(5), .SKID(1), .NOP_CTRL(4'b0000)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data_a(in_a), .in_data_b(in_b), .in_dst(in_dst),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data_a(out_a), .out_data_b(out_b), .out_dst(out_dst)
    );

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(4), .DST_W(5), .SKID(0), .NOP_CTRL(4'b0000)) dut0 (
        .clk(clk), .rst(rst), .flush(z_flush),
        .in_valid(z_in_valid), .in_ready(z_in_ready),
        .in_ctrl(z_in_ctrl), .in_data_a(z_in_a), .in_data_b(z_in_b), .in_dst(z_in_dst),
        .out_valid(z_out_valid), .out_ready(z_out_ready),
        .out_ctrl(z_out_ctrl), .out_data_a(z_out_a), .out_data_b(z_out_b), .out_dst(z_out_dst)
    );

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: a FIFO of at most two entries; flush/reset empty it, one push and one pop per cycle.
    always @(negedge clk) begin
        automatic int   sz = exp_q.size();
        automatic logic pop;
        automatic logic push;
        automatic ent_t cur;
        if (rst) begin
            chk("rst_out_valid", 80'(out_valid), 80'd0);
            chk("rst_out_ctrl", 80'(out_ctrl), 80'd0);
            chk("rst_out_data", 80'({out_a, out_b, out_dst}), 80'd0);
            chk("rst_in_ready", 80'(in_ready), 80'd1);
            exp_q.delete();
        end else begin
            chk("out_valid", 80'(out_valid), 80'(sz != 0));
            chk("in_ready", 80'(in_ready), 80'(sz < 2));
            if (sz != 0 && out_valid) begin
                cur = {out_ctrl, out_a, out_b, out_dst};
                chk("payload", 80'(cur), 80'(exp_q[0]));
            end else if (!out_valid) begin
                chk("bubble_ctrl", 80'(out_ctrl), 80'd0);
            end
            if (flush) begin
                exp_q.delete();
            end else begin
                pop  = (sz != 0) && out_ready;
                push = in_valid && (sz < 2);
                if (pop) void'(exp_q.pop_front());
                if (push) exp_q.push_back({in_ctrl, in_a, in_b, in_dst});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input ent_t e);
        in_valid = v;
        in_ctrl  = e.ctrl;
        in_a     = e.a;
        in_b     = e.b;
        in_dst   = e.dst;
    endtask

    function automatic ent_t mk(input logic [31:0] a);
        ent_t e;
        e.ctrl = 4'($urandom);
        e.a    = a;
        e.b    = $urandom;
        e.dst  = 5'($urandom);
        return e;
    endfunction

    // Present an entry and hold it until the stage accepts it.
    task automatic send(input ent_t e);
        set_in(1'b1, e);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready && !flush) begin
                step();
                in_valid = 1'b0;
                return;
            end
            step();
        end
        checks++;
        $display("FAIL send_timeout: entry a=%0h never accepted", e.a);
        in_valid = 1'b0;
    endtask

    initial begin
        ent_t e;
        repeat (2) step();
        rst = 1'b0;
        step();

        // Back-to-back streaming 1..8.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) send(mk(i));
        repeat (3) step();

        // One-cycle bubble between two entries carrying write enables.
        e = mk(20); e.ctrl = 4'b1001; send(e);
        step();
        e = mk(21); e.ctrl = 4'b1001; send(e);
        repeat (3) step();

        // Back-pressure: 5 held, 6 into skid, 7 waits upstream.
        out_ready = 1'b0;
        send(mk(5));
        send(mk(6));
        e = mk(7);
        set_in(1'b1, e);
        repeat (3) step();
        out_ready = 1'b1;
        send(e);
        repeat (4) step();

        // Flush while full, with a competing input that must be discarded.
        out_ready = 1'b0;
        send(mk(5));
        send(mk(6));
        set_in(1'b1, mk(9));
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        // Asynchronous reset in the middle of a held transfer.
        out_ready = 1'b0;
        send(mk(32'h33));
        send(mk(32'h44));
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 80'(out_valid), 80'd0);
        chk("async_rst_ctrl", 80'(out_ctrl), 80'd0);
        chk("async_rst_data_a", 80'(out_a), 80'd0);
        chk("async_rst_in_ready", 80'(in_ready), 80'd1);
        step();
        rst = 1'b0;
        step();

        // Randomized traffic with occasional flush.
        for (int c = 0; c < 400; c++) begin
            out_ready = ($urandom % 4) != 0;
            flush     = ($urandom % 25) == 0;
            set_in(($urandom % 3) != 0, mk($urandom));
            step();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();

        // Single-entry build: in_ready follows out_ready combinationally.
        z_in_valid = 1'b1;
        z_in_a = 32'h11;
        z_in_ctrl = 4'b1000;
        z_out_ready = 1'b0;
        step();
        z_in_valid = 1'b0;
        #1;
        chk("skid0_held_valid", 80'(z_out_valid), 80'd1);
        chk("skid0_held_data", 80'(z_out_a), 80'h11);
        chk("skid0_in_ready_low", 80'(z_in_ready), 80'd0);
        z_out_ready = 1'b1;
        #1;
        chk("skid0_in_ready_high", 80'(z_in_ready), 80'd1);
        step();
        chk("skid0_drained", 80'(z_out_valid), 80'd0);
        chk("skid0_bubble_ctrl", 80'(z_out_ctrl), 80'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
